// File: rtl/fa_16bit_reg.sv
// Clocked ripple-carry adder: WIDTH full-adder cells feeding a result register.
// {cout,s} = a + b + cin, one cycle after in_valid.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

module fa_16bit_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .c  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Result holds across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fa_16bit_reg.sv
// Scoreboard bench for fa_16bit_reg.
// Expected sums are queued at drive time and popped at the result edge.

module tb_fa_16bit_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] s;
  logic        cout;
  logic        out_valid;

  int n_tests;
  int n_fail;

  logic [16:0] exp_q[$];
  logic [16:0] held;

  fa_16bit_reg #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c
  );
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Drive one cycle, then check outputs #1 after the edge.
  task automatic drive(
    input string       tag,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        v,
    input logic [16:0] want
  );
    logic [16:0] e;
    a        = x;
    b        = y;
    cin      = c;
    in_valid = v;
    if (v) exp_q.push_back(want);
    @(posedge clk);
    #1;
    check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      if (exp_q.size() == 0) begin
        check({tag, "_empty"}, 32'd1, 32'd0);
      end else begin
        e    = exp_q.pop_front();
        held = e;
        check(tag, {15'd0, cout, s}, {15'd0, e});
      end
    end else begin
      check({tag, "_hold"}, {15'd0, cout, s}, {15'd0, held});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s"}, {16'd0, s}, 32'd0);
    check({tag, "_c"}, {31'd0, cout}, 32'd0);
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    n_tests  = 0;
    n_fail   = 0;
    held     = '0;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 16'hA5A5;
    b        = 16'h5A5A;
    cin      = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero("rst_rel");

    drive("first", 16'h0001, 16'h0001, 1'b0, 1'b1, 17'h00002);
    drive("dir0", 16'h1215, 16'h3524, 1'b1, 1'b1, 17'h0473A);
    drive("dir1", 16'hB2C2, 16'h8465, 1'b0, 1'b1, 17'h13727);
    drive("dir2", 16'h00F3, 16'hE301, 1'b1, 1'b1, 17'h0E3F5);
    drive("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h10000);
    drive("allone", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF);
    drive("zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00000);

    drive("hold_v", 16'h1215, 16'h3524, 1'b1, 1'b1, 17'h0473A);
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      drive("hold", ra, rb, rc, 1'b0, 17'h0);
    end
    check("hold_val", {15'd0, cout, s}, 32'h0000473A);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      drive("stream", ra, rb, rc, 1'b1, model(ra, rb, rc));
      if (i == 99) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        exp_q.delete();
        held = '0;
        #1;
        rst_n = 1'b1;
        #1;
        check_zero("mid_rel");
      end
    end

    drive("tail_idle", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0);
    check("q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
